gemm_tile_sequencer: RTL and testbench
======================================

// Module: gemm_tile_sequencer
// PURPOSE
//  Sequences the NumPE_M x NumPE_N multi-input MAC array for one tiled GeMM C = A*B.
//  - Latches sizes on start and walks output tiles: m outer, n middle, k inner.
//  - Generates SRAM A/B/C word addresses and the PE control strobes: valid, init_save, acc_clr.
//  - Sits between the host start/done handshake and the PE array plus the SRAM macros.
// PARAMETERS
//  AddrWidth      16  SRAM word address width
//  SizeAddrWidth   8  width of M/K/N size inputs (elements)
//  NumPE_M         2  PE rows (power of 2)
//  NumPE_N         2  PE cols (power of 2)
//  NumIp_K        16  MAC inputs per PE (power of 2)
//  PerfWidth      32  perf counter width
// PORTS
//  clk_i            in   1              clock
//  rst_ni           in   1              async active-low reset
//  start_i          in   1              start pulse, honoured only in IDLE
//  M_size_i         in   SizeAddrWidth  rows of A/C (elements)
//  K_size_i         in   SizeAddrWidth  cols of A / rows of B
//  N_size_i         in   SizeAddrWidth  cols of B/C
//  sram_a_addr_o    out  AddrWidth      A word addr = m_t*K_t + k_t
//  sram_b_addr_o    out  AddrWidth      B word addr = n_t*K_t + k_t (column-tile major)
//  sram_c_addr_o    out  AddrWidth      C word addr = m_t*N_t + n_t
//  sram_c_we_o      out  1              C write strobe
//  pe_valid_o       out  1              SRAM data valid into PEs
//  pe_init_save_o   out  1              first k beat of a tile (PE loads product)
//  pe_acc_clr_o     out  1              clear accumulators
//  busy_o           out  1              operation in progress
//  done_o           out  1              1-cycle completion pulse
//  size_err_o       out  1              sticky until next start: size not tile multiple or tile count 0
//  perf_cycles_o    out  PerfWidth      busy-cycle count of last run
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0, except pe_acc_clr_o=1.
//  - Tile counts: M_t=M>>log2(NumPE_M), K_t=K>>log2(NumIp_K), N_t=N>>log2(NumPE_N).
//    Latched at start_i; size inputs are ignored afterwards.
//  - FSM IDLE -> RUN on start_i. If any tile count is 0: IDLE -> DONE directly, size_err_o=1, no writes.
//  - RUN: issues one (m_t,n_t,k_t) address per cycle, k_t innermost; counters wrap at K_t-1/N_t-1/M_t-1.
//  - RUN -> DRAIN after the last address (m_t=M_t-1, n_t=N_t-1, k_t=K_t-1).
//  - DRAIN: waits 2 cycles for the pipeline to empty, then -> DONE. DONE -> IDLE after 1 cycle.
//  - Pipeline, address issued in cycle t:
//    - pe_valid_o=1 in t+1 (1-cycle SRAM read latency).
//    - pe_init_save_o=1 in t+1 iff k_t==0.
//    - If k_t==K_t-1: sram_c_we_o=1 in t+2, with sram_c_addr_o = that tile's address.
//  - sram_c_addr_o is registered and holds its value between writes.
//  - done_o pulses exactly 1 cycle after the final sram_c_we_o, in state DONE.
//  - busy_o=1 in RUN and DRAIN.
//  - pe_acc_clr_o=1 in IDLE and DONE, 0 in RUN and DRAIN.
//  - start_i while busy_o=1 is ignored (no restart, no latch of sizes).
//  - start_i in the same cycle as done_o is ignored; a new start is accepted from IDLE only.
//  - size_err_o is also set (run proceeds, truncated) when a size has nonzero low bits below the tile size.
//  - Address math is unsigned, truncated to AddrWidth; no overflow detection.
//  - Reset asserted mid-run: everything returns to reset values immediately; no write or done is emitted.
// CONFIGURATION
//  GEMM_SEQ_PERF_EN defined:
//    - perf_cycles_o clears on accepted start.
//    - It increments every busy_o cycle and saturates at all-ones.
//    - It holds its value until the next start.
//  GEMM_SEQ_PERF_EN undefined:
//    - perf_cycles_o is tied to 0; no counter flops are built.
// STRUCTURE
//  - Package gemm_pkg holds:
//    - typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} gemm_seq_state_e
//    - tile_cnt_t, a SizeAddrWidth-wide logic type
//    - shift localparams derived from NumPE_M/NumPE_N/NumIp_K
//  - Sub-module gemm_tile_counter holds the 3-level nested wrap counter (k,n,m), with:
//    - inputs: en, clr, and the three limits
//    - outputs: counts and last_o
//  - This module owns the FSM, the 2-stage strobe pipeline, address math and the perf counter.
// TESTING
//  Defaults assumed (NumPE_M=2, NumPE_N=2, NumIp_K=16).
//  1. M=4,K=32,N=4, start at cycle 0:
//     - 8 issue cycles; writes at cycles 4,6,8,10 to C addr 0,1,2,3.
//     - done_o at cycle 11; perf=10 (macro on).
//  2. M=2,K=16,N=2 (1 tile):
//     - pe_valid_o and pe_init_save_o both 1 in cycle 2.
//     - one write to addr 0 in cycle 3; done in cycle 4.
//  3. K=8 (K_t=0):
//     - no pe_valid_o, no sram_c_we_o.
//     - done_o 1 cycle after start; size_err_o=1.
//  4. start_i re-pulsed at cycle 3 of scenario 1: ignored, same write sequence.
//  5. rst_ni low at cycle 5 of scenario 1:
//     - all outputs at reset values the same cycle.
//     - a later start runs scenario 1 cleanly.
//  6. M=6,K=48,N=4: A addr sequence 0,1,2,0,1,2,3,4,5...; C writes 0..5 in order.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared types and tile geometry defaults for the GeMM tile sequencer.
package gemm_pkg;

    localparam int unsigned TileCntWidth = 8;

    localparam int unsigned DefNumPeM = 2;
    localparam int unsigned DefNumPeN = 2;
    localparam int unsigned DefNumIpK = 16;

    localparam int unsigned ShiftM = $clog2(DefNumPeM);
    localparam int unsigned ShiftN = $clog2(DefNumPeN);
    localparam int unsigned ShiftK = $clog2(DefNumIpK);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} gemm_seq_state_e;

    typedef logic [TileCntWidth-1:0] tile_cnt_t;

endpackage

// File: rtl/gemm_tile_counter.sv
// Three-level nested wrap counter for the tile walk: k innermost, then n, then m.
module gemm_tile_counter
    import gemm_pkg::*;
#(
    parameter int unsigned W = TileCntWidth
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] lim_k_i,
    input  logic [W-1:0] lim_n_i,
    input  logic [W-1:0] lim_m_i,
    output logic [W-1:0] k_o,
    output logic [W-1:0] n_o,
    output logic [W-1:0] m_o,
    output logic         last_o
);

    logic k_last, n_last, m_last;

    assign k_last = (k_o == lim_k_i - W'(1));
    assign n_last = (n_o == lim_n_i - W'(1));
    assign m_last = (m_o == lim_m_i - W'(1));
    assign last_o = k_last && n_last && m_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            k_o <= '0;
            n_o <= '0;
            m_o <= '0;
        end else if (clr_i) begin
            k_o <= '0;
            n_o <= '0;
            m_o <= '0;
        end else if (en_i) begin
            if (k_last) begin
                k_o <= '0;
                if (n_last) begin
                    n_o <= '0;
                    m_o <= m_last ? '0 : m_o + W'(1);
                end else begin
                    n_o <= n_o + W'(1);
                end
            end else begin
                k_o <= k_o + W'(1);
            end
        end
    end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Tiled GeMM sequencer: FSM, SRAM address generation and PE strobe pipeline.
// Optional busy-cycle perf counter enabled by defining GEMM_SEQ_PERF_EN.
module gemm_tile_sequencer
    import gemm_pkg::*;
#(
    parameter int unsigned AddrWidth     = 16,
    parameter int unsigned SizeAddrWidth = TileCntWidth,
    parameter int unsigned NumPE_M       = DefNumPeM,
    parameter int unsigned NumPE_N       = DefNumPeN,
    parameter int unsigned NumIp_K       = DefNumIpK,
    parameter int unsigned PerfWidth     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     pe_valid_o,
    output logic                     pe_init_save_o,
    output logic                     pe_acc_clr_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     size_err_o,
    output logic [PerfWidth-1:0]     perf_cycles_o
);

    localparam int unsigned ShM = $clog2(NumPE_M);
    localparam int unsigned ShN = $clog2(NumPE_N);
    localparam int unsigned ShK = $clog2(NumIp_K);
    localparam logic [SizeAddrWidth-1:0] MaskM = SizeAddrWidth'(NumPE_M - 1);
    localparam logic [SizeAddrWidth-1:0] MaskN = SizeAddrWidth'(NumPE_N - 1);
    localparam logic [SizeAddrWidth-1:0] MaskK = SizeAddrWidth'(NumIp_K - 1);

    gemm_seq_state_e state_q, state_d;

    logic [SizeAddrWidth-1:0] m_in, k_in, n_in;
    logic [SizeAddrWidth-1:0] mt_q, kt_q, nt_q;
    logic [SizeAddrWidth-1:0] m_cnt, k_cnt, n_cnt;
    logic                     start_ok, zero_tiles, low_bits, issue, last, drain_q;
    logic                     v1_q, init1_q, we1_q, we2_q;
    logic [AddrWidth-1:0]     c_addr1_q, c_addr_q, c_addr_next;

    assign m_in       = M_size_i >> ShM;
    assign k_in       = K_size_i >> ShK;
    assign n_in       = N_size_i >> ShN;
    assign zero_tiles = (m_in == '0) || (k_in == '0) || (n_in == '0);
    assign low_bits   = ((M_size_i & MaskM) != '0) || ((K_size_i & MaskK) != '0)
                      || ((N_size_i & MaskN) != '0);
    assign start_ok   = start_i && (state_q == IDLE);

    always_comb begin
        state_d      = state_q;
        issue        = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        pe_acc_clr_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                pe_acc_clr_o = 1'b1;
                if (start_i) state_d = zero_tiles ? DONE : RUN;
            end
            RUN: begin
                issue  = 1'b1;
                busy_o = 1'b1;
                if (last) state_d = DRAIN;
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (drain_q) state_d = DONE;
            end
            DONE: begin
                done_o       = 1'b1;
                pe_acc_clr_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            drain_q    <= 1'b0;
            mt_q       <= '0;
            kt_q       <= '0;
            nt_q       <= '0;
            size_err_o <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
            if (start_ok) begin
                mt_q       <= m_in;
                kt_q       <= k_in;
                nt_q       <= n_in;
                size_err_o <= zero_tiles || low_bits;
            end
        end
    end

    gemm_tile_counter #(
        .W (SizeAddrWidth)
    ) u_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (issue),
        .clr_i   (start_ok),
        .lim_k_i (kt_q),
        .lim_n_i (nt_q),
        .lim_m_i (mt_q),
        .k_o     (k_cnt),
        .n_o     (n_cnt),
        .m_o     (m_cnt),
        .last_o  (last)
    );

    assign sram_a_addr_o = AddrWidth'(m_cnt) * AddrWidth'(kt_q) + AddrWidth'(k_cnt);
    assign sram_b_addr_o = AddrWidth'(n_cnt) * AddrWidth'(kt_q) + AddrWidth'(k_cnt);
    assign c_addr_next   = AddrWidth'(m_cnt) * AddrWidth'(nt_q) + AddrWidth'(n_cnt);

    // Stage 1 aligns with SRAM read data; stage 2 is the write-back of the finished tile.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q      <= 1'b0;
            init1_q   <= 1'b0;
            we1_q     <= 1'b0;
            we2_q     <= 1'b0;
            c_addr1_q <= '0;
            c_addr_q  <= '0;
        end else begin
            v1_q      <= issue;
            init1_q   <= issue && (k_cnt == '0);
            we1_q     <= issue && (k_cnt == kt_q - SizeAddrWidth'(1));
            we2_q     <= we1_q;
            c_addr1_q <= c_addr_next;
            if (we1_q) c_addr_q <= c_addr1_q;
        end
    end

    assign pe_valid_o     = v1_q;
    assign pe_init_save_o = init1_q;
    assign sram_c_we_o    = we2_q;
    assign sram_c_addr_o  = c_addr_q;

`ifdef GEMM_SEQ_PERF_EN
    logic [PerfWidth-1:0] perf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (start_ok) begin
            perf_q <= '0;
        end else if (busy_o && (perf_q != '1)) begin
            perf_q <= perf_q + PerfWidth'(1);
        end
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed self-checking bench for gemm_tile_sequencer (default geometry 2x2x16).
module tb_gemm_tile_sequencer;

`ifdef GEMM_SEQ_PERF_EN
    localparam bit PerfOn = 1'b1;
`else
    localparam bit PerfOn = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [7:0]  M_size_i, K_size_i, N_size_i;
    logic [15:0] sram_a_addr_o, sram_b_addr_o, sram_c_addr_o;
    logic        sram_c_we_o, pe_valid_o, pe_init_save_o, pe_acc_clr_o;
    logic        busy_o, done_o, size_err_o;
    logic [31:0] perf_cycles_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] obs_a    [0:31];
    logic [15:0] obs_b    [0:31];
    logic [15:0] obs_c    [0:31];
    logic        obs_we   [0:31];
    logic        obs_v    [0:31];
    logic        obs_init [0:31];
    logic        obs_busy [0:31];
    logic        obs_done [0:31];
    logic        obs_clr  [0:31];
    logic        obs_err  [0:31];

    gemm_tile_sequencer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .M_size_i       (M_size_i),
        .K_size_i       (K_size_i),
        .N_size_i       (N_size_i),
        .sram_a_addr_o  (sram_a_addr_o),
        .sram_b_addr_o  (sram_b_addr_o),
        .sram_c_addr_o  (sram_c_addr_o),
        .sram_c_we_o    (sram_c_we_o),
        .pe_valid_o     (pe_valid_o),
        .pe_init_save_o (pe_init_save_o),
        .pe_acc_clr_o   (pe_acc_clr_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .size_err_o     (size_err_o),
        .perf_cycles_o  (perf_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " a_addr"}, 32'(sram_a_addr_o), 0);
        chk({tag, " b_addr"}, 32'(sram_b_addr_o), 0);
        chk({tag, " c_addr"}, 32'(sram_c_addr_o), 0);
        chk({tag, " c_we"}, 32'(sram_c_we_o), 0);
        chk({tag, " valid"}, 32'(pe_valid_o), 0);
        chk({tag, " init"}, 32'(pe_init_save_o), 0);
        chk({tag, " acc_clr"}, 32'(pe_acc_clr_o), 1);
        chk({tag, " busy"}, 32'(busy_o), 0);
        chk({tag, " done"}, 32'(done_o), 0);
        chk({tag, " err"}, 32'(size_err_o), 0);
        chk({tag, " perf"}, perf_cycles_o, 0);
    endtask

    // Called at a negedge with the DUT idle; start_i is high during cycle 0.
    task automatic run(input logic [7:0] m, input logic [7:0] k, input logic [7:0] n,
                       input int ncyc, input int restart);
        M_size_i = m;
        K_size_i = k;
        N_size_i = n;
        start_i  = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk_i);
            start_i     = (c == restart);
            M_size_i    = 8'hFF;
            K_size_i    = 8'hFF;
            N_size_i    = 8'hFF;
            obs_a[c]    = sram_a_addr_o;
            obs_b[c]    = sram_b_addr_o;
            obs_c[c]    = sram_c_addr_o;
            obs_we[c]   = sram_c_we_o;
            obs_v[c]    = pe_valid_o;
            obs_init[c] = pe_init_save_o;
            obs_busy[c] = busy_o;
            obs_done[c] = done_o;
            obs_clr[c]  = pe_acc_clr_o;
            obs_err[c]  = size_err_o;
        end
        start_i = 1'b0;
    endtask

    task automatic check_run(input string tag, input logic [31:0] we_m,
                             input logic [31:0] v_m, input logic [31:0] init_m,
                             input int ncyc, input int done_c, input int busy_last,
                             input logic err_exp, input logic [31:0] perf_exp);
        int widx = 0;
        for (int c = 1; c <= ncyc; c++) begin
            chk($sformatf("%s we@%0d", tag, c), 32'(obs_we[c]), 32'(we_m[c]));
            if (we_m[c]) begin
                chk($sformatf("%s c_addr@%0d", tag, c), 32'(obs_c[c]), widx);
                widx++;
            end
            chk($sformatf("%s valid@%0d", tag, c), 32'(obs_v[c]), 32'(v_m[c]));
            chk($sformatf("%s init@%0d", tag, c), 32'(obs_init[c]), 32'(init_m[c]));
            chk($sformatf("%s done@%0d", tag, c), 32'(obs_done[c]), 32'(c == done_c));
            chk($sformatf("%s busy@%0d", tag, c), 32'(obs_busy[c]), 32'(c <= busy_last));
            chk($sformatf("%s acc_clr@%0d", tag, c), 32'(obs_clr[c]), 32'(c > busy_last));
        end
        chk({tag, " err"}, 32'(obs_err[1]), 32'(err_exp));
        chk({tag, " perf"}, perf_cycles_o, PerfOn ? perf_exp : 32'd0);
    endtask

    initial begin
        int exp_a1 [1:8]  = '{0, 1, 0, 1, 2, 3, 2, 3};
        int exp_b1 [1:8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_a6 [1:18] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5, 6, 7, 8, 6, 7, 8};

        rst_ni   = 1'b0;
        start_i  = 1'b0;
        M_size_i = '0;
        K_size_i = '0;
        N_size_i = '0;
        #1;
        check_reset("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // 2x2 tiles, K_t=2
        run(8'd4, 8'd32, 8'd4, 12, 0);
        check_run("s1", 32'h0000_0550, 32'h0000_03FC, 32'h0000_0154, 12, 11, 10, 1'b0, 32'd10);
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("s1 a_addr@%0d", c), 32'(obs_a[c]), exp_a1[c]);
            chk($sformatf("s1 b_addr@%0d", c), 32'(obs_b[c]), exp_b1[c]);
        end

        // single tile; restart on the done cycle must be ignored
        run(8'd2, 8'd16, 8'd2, 6, 4);
        check_run("s2", 32'h0000_0008, 32'h0000_0004, 32'h0000_0004, 6, 4, 3, 1'b0, 32'd3);

        // K_t=0: straight to DONE with error
        run(8'd4, 8'd8, 8'd4, 3, 0);
        check_run("s3", 32'h0, 32'h0, 32'h0, 3, 1, 0, 1'b1, 32'd0);

        // restart while busy is ignored; clean start clears the sticky error
        run(8'd4, 8'd32, 8'd4, 12, 3);
        check_run("s4", 32'h0000_0550, 32'h0000_03FC, 32'h0000_0154, 12, 11, 10, 1'b0, 32'd10);

        // M=5 leaves a remainder: error flagged, run truncated to M_t=2
        run(8'd5, 8'd32, 8'd4, 12, 0);
        check_run("odd", 32'h0000_0550, 32'h0000_03FC, 32'h0000_0154, 12, 11, 10, 1'b1, 32'd10);

        // reset mid-run at cycle 5
        run(8'd4, 8'd32, 8'd4, 4, 0);
        @(negedge clk_i);
        chk("s5 busy before reset", 32'(busy_o), 1);
        rst_ni = 1'b0;
        #1;
        check_reset("s5 async");
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (c == 1) rst_ni = 1'b1;
            chk($sformatf("s5 no we %0d", c), 32'(sram_c_we_o), 0);
            chk($sformatf("s5 no done %0d", c), 32'(done_o), 0);
        end
        run(8'd4, 8'd32, 8'd4, 12, 0);
        check_run("s5 rerun", 32'h0000_0550, 32'h0000_03FC, 32'h0000_0154, 12, 11, 10, 1'b0, 32'd10);

        // M_t=3, K_t=3, N_t=2
        run(8'd6, 8'd48, 8'd4, 22, 0);
        check_run("s6", 32'h0012_4920, 32'h000F_FFFC, 32'h0002_4924, 22, 21, 20, 1'b0, 32'd20);
        for (int c = 1; c <= 18; c++) begin
            chk($sformatf("s6 a_addr@%0d", c), 32'(obs_a[c]), exp_a6[c]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed no completion, required finish before 200000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
